imp_moment_unit: RTL and testbench

Streaming first- and second-moment unit for the LayerNorm datapath. It accumulates frames of N = 2^LOG2N signed samples and returns E[x] and E[x²] per frame using power-of-two shift division, with selectable truncation or rounding. Accepted samples and delivered results both use valid/ready handshakes. A one-entry result register lets the next frame accumulate back-to-back while the previous result waits downstream. It sits ahead of the variance/normalisation stage and generalises the single-moment mean unit in width, depth and rounding mode.

---
 rtl/imp_moment_unit.sv | 134 +++++++++++++
 tb/tb_imp_moment_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imp_moment_unit.sv
// imp_moment_unit
// Streaming first/second moment unit: accumulates frames of 2^LOG2N signed
// samples and returns E[x] and E[x^2] per frame through a one-entry result
// slot, so the next frame can accumulate while a result waits downstream.

module imp_moment_unit #(
  parameter int DATA_W = 8,
  parameter int LOG2N  = 3,
  parameter int ROUND  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_W-1:0]     i_x,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_W-1:0]     o_ex,
  output logic [2*DATA_W-1:0]   o_ex2
);

  localparam int SUM_W = DATA_W + LOG2N;
  localparam int SQ_W  = 2 * DATA_W + LOG2N;
  localparam int EX2_W = 2 * DATA_W;
  localparam int RND   = (ROUND != 0) ? (1 << (LOG2N - 1)) : 0;
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_e;

  slot_e slot_q;
  slot_e slot_d;

  logic signed [SUM_W-1:0]    sum_p0;
  logic        [SQ_W-1:0]     sq_p0;
  logic        [LOG2N-1:0]    cnt_p0;

  logic signed [DATA_W-1:0]   ex_p1;
  logic        [EX2_W-1:0]    ex2_p1;
  logic                       vld_p1;

  logic signed [DATA_W-1:0]   x_s;
  logic signed [2*DATA_W-1:0] x_sq;
  logic signed [SUM_W-1:0]    sum_f;
  logic        [SQ_W-1:0]     sq_f;
  logic                       cnt_at_last;
  logic                       accept;
  logic                       last_acc;
  logic                       pop;

  // Mean: the sum plus the rounding bias cannot overflow SUM_W, so the
  // arithmetic shift result always fits back in DATA_W bits.
  function automatic logic signed [DATA_W-1:0] mean_shift(
    input logic signed [SUM_W-1:0] s
  );
    logic signed [SUM_W-1:0] t;
    t = s + SUM_W'(RND);
    return DATA_W'(t >>> LOG2N);
  endfunction

  // Mean of squares: the largest square is 2^(2*DATA_W-2), so the shifted
  // value fits in 2*DATA_W bits without saturation.
  function automatic logic [EX2_W-1:0] sq_shift(
    input logic [SQ_W-1:0] s
  );
    logic [SQ_W-1:0] t;
    t = s + SQ_W'(RND);
    return EX2_W'(t >> LOG2N);
  endfunction

  assign x_s         = $signed(i_x);
  assign x_sq        = x_s * x_s;
  assign sum_f       = sum_p0 + SUM_W'(x_s);
  assign sq_f        = sq_p0 + SQ_W'($unsigned(x_sq));
  assign cnt_at_last = (cnt_p0 == CNT_LAST);
  assign vld_p1      = (slot_q == SLOT_FULL);

  // The last sample of a frame may only stall while the slot holds a result
  // that is not being popped this cycle; i_ready feeds o_ready directly.
  assign o_ready  = !i_rst && !i_clr && !(cnt_at_last && vld_p1 && !i_ready);
  assign accept   = i_valid && o_ready;
  assign last_acc = accept && cnt_at_last;
  assign pop      = vld_p1 && i_ready;

  assign o_valid = vld_p1;
  assign o_ex    = vld_p1 ? ex_p1  : '0;
  assign o_ex2   = vld_p1 ? ex2_p1 : '0;

  // ---- stage p0: frame accumulation ----
  // Accumulate accepted samples; restart on reset, flush or frame completion.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || last_acc) begin
      sum_p0 <= '0;
      sq_p0  <= '0;
      cnt_p0 <= '0;
    end else if (accept) begin
      sum_p0 <= sum_f;
      sq_p0  <= sq_f;
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // ---- stage p1: result slot ----
  // Capture the finished frame's moments, including the final sample.
  always_ff @(posedge i_clk) begin
    if (last_acc) begin
      ex_p1  <= mean_shift(sum_f);
      ex2_p1 <= sq_shift(sq_f);
    end
  end

  // Result slot occupancy register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_q <= SLOT_EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Slot fills on a last-sample accept (even while popping) and empties on a pop.
  always_comb begin
    slot_d = slot_q;
    if (last_acc) begin
      slot_d = SLOT_FULL;
    end else if (pop) begin
      slot_d = SLOT_EMPTY;
    end
  end

endmodule

// File: tb/tb_imp_moment_unit.sv
// Directed bench for imp_moment_unit: floor and rounding instances share one
// stimulus stream; a wider/deeper instance covers the large-parameter case.

module tb_imp_moment_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the DATA_W=8, LOG2N=3 instances
  logic        rst, clr, vld, rdy_in;
  logic [7:0]  x;
  logic        rdy0, val0, rdy1, val1;
  logic [7:0]  ex0, ex1;
  logic [15:0] ex20, ex21;

  // Stimulus for the DATA_W=12, LOG2N=5 instance
  logic        rst2, clr2, vld2, rdy_in2;
  logic [11:0] x2;
  logic        rdy2, val2;
  logic [11:0] ex2_m;
  logic [23:0] ex2_s;

  int n_cmp = 0;
  int n_bad = 0;

  imp_moment_unit #(.DATA_W(8), .LOG2N(3), .ROUND(0)) u_floor (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(vld), .o_ready(rdy0),
    .i_x(x), .o_valid(val0), .i_ready(rdy_in), .o_ex(ex0), .o_ex2(ex20)
  );

  imp_moment_unit #(.DATA_W(8), .LOG2N(3), .ROUND(1)) u_round (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(vld), .o_ready(rdy1),
    .i_x(x), .o_valid(val1), .i_ready(rdy_in), .o_ex(ex1), .o_ex2(ex21)
  );

  imp_moment_unit #(.DATA_W(12), .LOG2N(5), .ROUND(0)) u_wide (
    .i_clk(clk), .i_rst(rst2), .i_clr(clr2), .i_valid(vld2), .o_ready(rdy2),
    .i_x(x2), .o_valid(val2), .i_ready(rdy_in2), .o_ex(ex2_m), .o_ex2(ex2_s)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Present one sample from a negedge, wait (bounded) for acceptance, and
  // return at the negedge after the accepting edge with i_valid low.
  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    vld = 1'b1;
    x   = v;
    #1;
    while (!rdy0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) check_eq("send_timeout", 0, 1);
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic send2(input logic [11:0] v);
    int n;
    n = 0;
    vld2 = 1'b1;
    x2   = v;
    #1;
    while (!rdy2 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) check_eq("send2_timeout", 0, 1);
    @(negedge clk);
    vld2 = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; vld = 1'b0; rdy_in = 1'b1; x = '0;
    rst2 = 1'b1; clr2 = 1'b0; vld2 = 1'b0; rdy_in2 = 1'b1; x2 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_ready", rdy0, 0);
    check_eq("rst_valid", val0, 0);
    check_eq("rst_ex", ex0, 0);
    check_eq("rst_ex2", ex20, 0);
    rst = 1'b0;
    rst2 = 1'b0;
    #1;
    check_eq("post_rst_ready", rdy0, 1);

    // Samples 1..8, both rounding modes
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      if (i == 7) check_eq("seq_early_valid", val0, 0);
    end
    check_eq("seq_valid_f", val0, 1);
    check_eq("seq_ex_f", ex0, 4);
    check_eq("seq_ex2_f", ex20, 25);
    check_eq("seq_valid_r", val1, 1);
    check_eq("seq_ex_r", ex1, 5);
    check_eq("seq_ex2_r", ex21, 26);
    @(negedge clk);
    check_eq("seq_valid_1cyc_f", val0, 0);
    check_eq("seq_valid_1cyc_r", val1, 0);

    // Extremes
    for (int i = 0; i < 8; i++) send(8'h80);
    check_eq("neg_ex", ex0, 8'h80);
    check_eq("neg_ex2", ex20, 16384);
    check_eq("neg_ex_r", ex1, 8'h80);
    for (int i = 0; i < 8; i++) send(8'd127);
    check_eq("pos_ex", ex0, 127);
    check_eq("pos_ex2", ex20, 16129);
    check_eq("pos_ex2_r", ex21, 16129);

    // -1 followed by zeros: floor vs round
    send(8'hFF);
    for (int i = 0; i < 7; i++) send(8'd0);
    check_eq("m1_ex_f", ex0, 8'hFF);
    check_eq("m1_ex2_f", ex20, 0);
    check_eq("m1_ex_r", ex1, 0);
    check_eq("m1_ex2_r", ex21, 0);
    check_eq("m1_valid_r", val1, 1);
    @(negedge clk);

    // Backpressure across two frames
    rdy_in = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i));
    check_eq("bp_first_valid", val0, 1);
    check_eq("bp_first_ex", ex0, 4);
    for (int i = 0; i < 7; i++) send(8'd2);
    check_eq("bp_hold_ex", ex0, 4);
    check_eq("bp_hold_ex2", ex20, 25);
    vld = 1'b1;
    x = 8'd2;
    #1;
    check_eq("bp_stall_ready", rdy0, 0);
    @(negedge clk);
    #1;
    check_eq("bp_stall_ready2", rdy0, 0);
    check_eq("bp_stable_ex", ex0, 4);
    rdy_in = 1'b1;
    #1;
    check_eq("bp_release_ready", rdy0, 1);
    @(negedge clk);
    vld = 1'b0;
    check_eq("bp_second_valid", val0, 1);
    check_eq("bp_second_ex", ex0, 2);
    check_eq("bp_second_ex2", ex20, 4);
    @(negedge clk);
    check_eq("bp_drained", val0, 0);

    // Clear drops partial frame and the sample presented with it
    for (int i = 0; i < 3; i++) send(8'd50);
    clr = 1'b1;
    vld = 1'b1;
    x = 8'd99;
    #1;
    check_eq("clr_ready", rdy0, 0);
    @(negedge clk);
    clr = 1'b0;
    vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(8'd10);
      if (i < 7) check_eq("clr_no_early", val0, 0);
    end
    check_eq("clr_valid", val0, 1);
    check_eq("clr_ex", ex0, 10);
    check_eq("clr_ex2", ex20, 100);
    @(negedge clk);

    // Reset with a pending result and a partial frame
    rdy_in = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i));
    for (int i = 0; i < 5; i++) send(8'd7);
    check_eq("rst_pend_valid", val0, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_valid", val0, 0);
    check_eq("rst_mid_ex", ex0, 0);
    check_eq("rst_mid_ex2", ex20, 0);
    check_eq("rst_mid_ready", rdy0, 0);
    rst = 1'b0;
    rdy_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'd3);
      if (i < 7) check_eq("rst_new_no_early", val0, 0);
    end
    check_eq("rst_new_valid", val0, 1);
    check_eq("rst_new_ex", ex0, 3);
    check_eq("rst_new_ex2", ex20, 9);
    check_eq("rst_new_ex_r", ex1, 3);
    @(negedge clk);

    // Wide/deep instance: partial frame, reset, full frame of -2048
    for (int i = 0; i < 5; i++) send2(12'h800);
    rst2 = 1'b1;
    @(negedge clk);
    check_eq("wide_rst_valid", val2, 0);
    check_eq("wide_rst_ex", ex2_m, 0);
    rst2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send2(12'h800);
      if (i == 30) check_eq("wide_no_early", val2, 0);
    end
    check_eq("wide_valid", val2, 1);
    check_eq("wide_ex", ex2_m, 12'h800);
    check_eq("wide_ex2", ex2_s, 4194304);
    @(negedge clk);
    check_eq("wide_drained", val2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
